// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 256-byte little-endian memory responder with fixed-latency valid/ready responses
// Optional feature: define MEM_RESPONDER_ALIGN_CHECK_EN to fault misaligned half/word accesses
// (otherwise the low address bits are cleared and the access proceeds).
`timescale 1ns/1ps
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 1  // 0..15, idle cycles between acceptance and response
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic [7:0]  mem_q [256];

  logic        cur_wr;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  nbytes;
  logic        size_err;
  logic        range_err;
  logic        align_err;
  logic        err_d;
  logic [7:0]  a0, a1, a2, a3;
  logic [31:0] word_rd;
  logic [31:0] rdata_d;
  logic        enter_resp;
  logic        commit;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Decode the request being completed: live inputs when leaving IDLE directly, captured copy from WAIT
  always_comb begin
    cur_wr    = (state_q == ST_IDLE) ? req_wr    : wr_q;
    cur_size  = (state_q == ST_IDLE) ? req_size  : size_q;
    cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

    case (cur_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase

    size_err  = (cur_size == 2'b11);
    // Span is judged on the raw address, so a word at 0xFE faults even when low bits would be cleared
    range_err = (|cur_addr[31:8]) || (({1'b0, cur_addr[7:0]} + {6'b0, nbytes}) > 9'd256);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    align_err = ((cur_size == 2'b01) && cur_addr[0]) ||
                ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
    a0        = cur_addr[7:0];
`else
    align_err = 1'b0;
    case (cur_size)
      2'b01:   a0 = {cur_addr[7:1], 1'b0};
      2'b10:   a0 = {cur_addr[7:2], 2'b00};
      default: a0 = cur_addr[7:0];
    endcase
`endif

    err_d = size_err || range_err || align_err;
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    word_rd = {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[a0]};

    rdata_d = 32'd0;
    if (!err_d && !cur_wr) begin
      case (cur_size)
        2'b00:   rdata_d = {24'd0, word_rd[7:0]};
        2'b01:   rdata_d = {16'd0, word_rd[15:0]};
        default: rdata_d = word_rd;
      endcase
    end

    enter_resp = ((state_q == ST_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                 ((state_q == ST_WAIT) && (cnt_q == 4'd1));
    // A reset on the would-be commit edge drops the pending write
    commit = enter_resp && !reset && cur_wr && !err_d;
  end

  // Storage: written only on the edge entering RESP; never cleared by reset
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_q[a0] <= cur_wdata[7:0];
      if (cur_size != 2'b00) begin
        mem_q[a1] <= cur_wdata[15:8];
      end
      if (cur_size == 2'b10) begin
        mem_q[a2] <= cur_wdata[23:16];
        mem_q[a3] <= cur_wdata[31:24];
      end
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q        <= req_wr;
            size_q      <= req_size;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= rdata_d;
              resp_err_q   <= err_d;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q      <= ST_RESP;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rdata_d;
            resp_err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
